// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer, empty/almost-empty flags, fill level and sticky underflow
// for an asynchronous FIFO. Consumes the synchronized Gray write pointer.
module rptr_empty_lvl #(
  parameter int unsigned ASIZE = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   WSR2_ptr,
  input  logic [ASIZE:0]   ae_thresh,
  input  logic             underflow_clr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          rae_q,    rae_d;
  logic          runf_q,   runf_d;
  logic          pop;
  logic [PW-1:0] wbin;

  // Next-state: pointer advance, Gray image, level and flags all derive from rbin_d
  always_comb begin
    pop      = rinc & ~rempty_q;
    rbin_d   = rbin_q + PW'(pop);
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    wbin     = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin[i] = ^(WSR2_ptr >> i);
    end
    rlevel_d = wbin - rbin_d;
    rempty_d = (rptr_d == WSR2_ptr);
    rae_d    = (rlevel_d <= ae_thresh);
    // A read attempt while empty beats a concurrent clear
    runf_d   = (rinc & rempty_q) | (runf_q & ~underflow_clr);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      runf_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      runf_q   <= runf_d;
    end
  end

  assign rptr          = rptr_q;
  assign raddr         = rbin_q[ASIZE-1:0];
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runf_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed, table-driven bench for rptr_empty_lvl (ASIZE=4) with hand sequences
// for reset, full drain, and pointer wrap-around.
module tb_rptr_empty_lvl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] WSR2_ptr;
  logic [4:0] ae_thresh;
  logic       underflow_clr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int passed = 0;
  int total  = 0;

  rptr_empty_lvl #(.ASIZE(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .WSR2_ptr(WSR2_ptr),
    .ae_thresh(ae_thresh), .underflow_clr(underflow_clr), .rptr(rptr),
    .raddr(raddr), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       rinc;
    logic [4:0] wptr;
    logic [4:0] ae;
    logic       clr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       empty;
    logic       aef;
    logic [4:0] lvl;
    logic       unf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic [4:0] ep,
                         input logic ee, input logic eae, input logic [4:0] el, input logic eu);
    chk({tag, ".raddr"}, 32'(raddr), 32'(ea));
    chk({tag, ".rptr"}, 32'(rptr), 32'(ep));
    chk({tag, ".rempty"}, 32'(rempty), 32'(ee));
    chk({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(eae));
    chk({tag, ".rlevel"}, 32'(rlevel), 32'(el));
    chk({tag, ".runderflow"}, 32'(runderflow), 32'(eu));
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic [4:0] prev;
    logic [4:0] rb;

    //            rinc wptr      ae     clr   raddr rptr      e     ae    lvl    unf
    vecs[0]  = '{1'b0, 5'b00000, 5'd2,  1'b0, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 5'b00010, 5'd2,  1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b0};
    vecs[2]  = '{1'b1, 5'b00010, 5'd2,  1'b0, 4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b0};
    vecs[3]  = '{1'b1, 5'b00010, 5'd2,  1'b0, 4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[4]  = '{1'b1, 5'b00010, 5'd2,  1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 5'b00010, 5'd2,  1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[6]  = '{1'b1, 5'b00010, 5'd2,  1'b1, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[7]  = '{1'b0, 5'b00010, 5'd2,  1'b1, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 5'b00111, 5'd2,  1'b0, 4'd3, 5'b00010, 1'b0, 1'b1, 5'd2, 1'b0};
    vecs[9]  = '{1'b1, 5'b00100, 5'd2,  1'b0, 4'd4, 5'b00110, 1'b0, 1'b0, 5'd3, 1'b0};
    vecs[10] = '{1'b0, 5'b00100, 5'd0,  1'b0, 4'd4, 5'b00110, 1'b0, 1'b0, 5'd3, 1'b0};
    vecs[11] = '{1'b0, 5'b00100, 5'd16, 1'b0, 4'd4, 5'b00110, 1'b0, 1'b1, 5'd3, 1'b0};

    rrst_n = 1'b0; rinc = 1'b0; WSR2_ptr = '0; ae_thresh = 5'd2; underflow_clr = 1'b0;
    #12;
    chk_all("reset", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge rclk);
    rrst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      rinc = vecs[i].rinc; WSR2_ptr = vecs[i].wptr;
      ae_thresh = vecs[i].ae; underflow_clr = vecs[i].clr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].rptr, vecs[i].empty,
              vecs[i].aef, vecs[i].lvl, vecs[i].unf);
    end

    // Level 5 then asynchronous reset between clock edges
    rinc = 1'b0; underflow_clr = 1'b0; ae_thresh = 5'd2; WSR2_ptr = g(5'd9);
    tick();
    chk("mid.rlevel", 32'(rlevel), 32'd5);
    #2 rrst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Full FIFO drained by 16 back-to-back pops
    WSR2_ptr = 5'b11000;
    @(negedge rclk);
    rrst_n = 1'b1;
    tick();
    chk_all("full", 4'd0, 5'd0, 1'b0, 1'b0, 5'd16, 1'b0);
    rinc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prev = rptr;
      tick();
      chk($sformatf("full.onebit%0d", i), 32'($countones(rptr ^ prev)), 32'd1);
      chk($sformatf("full.rptr%0d", i), 32'(rptr), 32'(g(5'(i + 1))));
      chk($sformatf("full.rlevel%0d", i), 32'(rlevel), 32'(15 - i));
      chk($sformatf("full.rempty%0d", i), 32'(rempty), 32'(i == 15));
    end
    rinc = 1'b0;
    chk("full.raddr", 32'(raddr), 32'd0);
    chk("full.rptr_end", 32'(rptr), 32'b11000);

    // Advance rbin to 30, then wrap through 31, 0, 1
    WSR2_ptr = g(5'd30); ae_thresh = 5'd0;
    tick();
    chk("pre.rlevel", 32'(rlevel), 32'd14);
    rinc = 1'b1;
    repeat (14) tick();
    rinc = 1'b0;
    chk("pre.raddr", 32'(raddr), 32'd14);
    chk("pre.rempty", 32'(rempty), 32'd1);
    WSR2_ptr = 5'b00001;
    tick();
    chk("wrap.rlevel", 32'(rlevel), 32'd3);
    chk("wrap.ae0", 32'(ralmost_empty), 32'(rempty));
    rinc = 1'b1;
    rb = 5'd30;
    for (int i = 0; i < 3; i++) begin
      prev = rptr;
      rb = rb + 5'd1;
      tick();
      chk($sformatf("wrap.raddr%0d", i), 32'(raddr), 32'(rb[3:0]));
      chk($sformatf("wrap.rptr%0d", i), 32'(rptr), 32'(g(rb)));
      chk($sformatf("wrap.onebit%0d", i), 32'($countones(rptr ^ prev)), 32'd1);
      chk($sformatf("wrap.rlevel%0d", i), 32'(rlevel), 32'(2 - i));
      chk($sformatf("wrap.rempty%0d", i), 32'(rempty), 32'(i == 2));
      chk($sformatf("wrap.ae_eq%0d", i), 32'(ralmost_empty), 32'(i == 2));
    end
    rinc = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rptr_empty_lvl.md
# rptr_empty_lvl

Read-side pointer and status block for the asynchronous FIFO, running entirely in the read clock domain. It extends the basic read-pointer/empty generator with a fill level, a programmable almost-empty flag and a sticky underflow flag. It takes the write pointer after the two-flop Gray synchronizer and supplies the read address to the dual-port RAM and the Gray read pointer to the write-side synchronizer.

## Interface
- ASIZE, 4, address width; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits (extra wrap bit)

- rclk  input  1  read clock; all state updates on rising edge
- rrst_n  input  1  asynchronous active-low reset
- rinc  input  1  read request; honoured only while rempty==0
- WSR2_ptr  input  ASIZE+1  synchronized write pointer, Gray coded
- ae_thresh  input  ASIZE+1  almost-empty threshold; quasi-static
- underflow_clr  input  1  clears runderflow
- rptr  output  ASIZE+1  registered Gray read pointer, sent to write domain
- raddr  output  ASIZE  RAM read address = rbin[ASIZE-1:0]
- rempty  output  1  registered empty flag
- ralmost_empty  output  1  registered, 1 when level <= ae_thresh
- rlevel  output  ASIZE+1  registered occupancy seen from read side, 0..2**ASIZE
- runderflow  output  1  sticky; set by a read attempt while empty

## Operation
- Internal registered binary pointer rbin (ASIZE+1 bits); rptr is its Gray image, updated in the same edge.
- pop = rinc & ~rempty; rbinnext = rbin + pop (mod 2**(ASIZE+1)); rgraynext = (rbinnext>>1) ^ rbinnext.
- wbin = Gray-to-binary of WSR2_ptr (combinational XOR prefix, MSB down).
- lvl_next = wbin - rbinnext, modulo 2**(ASIZE+1); always in 0..2**ASIZE for legal inputs.
- Edge updates: rbin<=rbinnext; rptr<=rgraynext; rempty<=(rgraynext==WSR2_ptr); rlevel<=lvl_next; ralmost_empty<=(lvl_next<=ae_thresh).
- rempty and (rlevel==0) must always agree.
- Underflow: rinc & rempty sets runderflow at next edge; pointer does not move. underflow_clr clears it; simultaneous set and clear -> set wins.
- Level is pessimistic: a stale WSR2_ptr can understate the level but never overstate it, so no read of unwritten data is possible.
- Wrap-around: rbin rolls from 2**(ASIZE+1)-1 to 0; the Gray pointer changes exactly one bit per pop, including at the wrap.
- ae_thresh=0 makes ralmost_empty equal rempty. ae_thresh>=2**ASIZE forces ralmost_empty=1.

## Timing
- Reset (asynchronous, immediate): rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
- Reset mid-operation discards pointer state; the first edge after release recomputes flags from WSR2_ptr.
- Pop latency: a rinc sampled high with rempty=0 advances raddr/rptr at that edge. The RAM read data for the old raddr is consumed in the same cycle.
- WSR2_ptr change -> rempty/rlevel/ralmost_empty update on the next rclk edge (1 cycle), on top of the 2-cycle synchronizer.
- A simultaneous pop and write-pointer advance update level by (+writes - 1) in one edge.
- Back-to-back pops: one per cycle with no bubbles. The last pop sets rempty at the same edge the pointer reaches wbin.

## Test plan
- Reset with WSR2_ptr=0 -> rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0; all hold with rinc=1.
- ASIZE=4, ae_thresh=2, WSR2_ptr=5'b00010 (bin 3) -> next edge rempty=0, rlevel=3, ralmost_empty=0. Hold rinc 3 cycles -> raddr 1,2,3; rlevel 2,1,0; ralmost_empty 1 from the first pop; rempty=1 after the third pop.
- Empty FIFO with rinc=1 for one cycle -> raddr unchanged, runderflow=1. Then underflow_clr=1 with rinc=1 -> stays 1. Then underflow_clr=1 with rinc=0 -> 0.
- Full case: rptr=0, WSR2_ptr=5'b11000 (bin 16) -> rlevel=16, rempty=0. 16 pops -> rptr=5'b11000, raddr=0, rempty=1. Check a one-bit rptr change per pop.
- Wrap: with rbin=30, WSR2_ptr=gray(1)=5'b00001 (level 3), pop 3 -> rbin 31, 0, 1; rempty=1; rlevel=0.
- Assert rrst_n low mid-stream with rlevel=5 -> all outputs at reset values immediately, with no clock edge required.
